// File: rtl/test_run_pkg.sv
// Shared types for the test-run controller: FSM state encoding and fail_reason codes.
package test_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEQ,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_t;

  localparam logic [1:0] REASON_NONE     = 2'd0;
  localparam logic [1:0] REASON_TIMEOUT  = 2'd1;
  localparam logic [1:0] REASON_EXTERNAL = 2'd2;
  localparam logic [1:0] REASON_ABORT    = 2'd3;

endpackage

// File: rtl/test_run_controller_stim_nco.sv
// Phase accumulator with triangle fold producing a differential stimulus code pair.
module stim_nco #(
  parameter int STIM_W  = 12,
  parameter int PHASE_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] step,
  output logic [STIM_W-1:0]  stim_p,
  output logic [STIM_W-1:0]  stim_m
);

  logic [PHASE_W-1:0] phase;
  logic [STIM_W-1:0]  fold;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  phase <= '0;
    else if (en)   phase <= phase + step;
    else           phase <= '0;
  end

  // MSB selects the falling half of the triangle.
  assign fold   = phase[PHASE_W-2 -: STIM_W];
  assign stim_p = phase[PHASE_W-1] ? ~fold : fold;
  assign stim_m = ~stim_p;

endmodule

// File: rtl/test_run_controller.sv
// Test-run controller: sequenced domain-reset release, run-cycle count, timeout and verdict latch.
// Define TEST_RUN_STIM_EN to build the triangle stimulus NCO; otherwise stim_p/stim_m read 0.
//
// state | meaning
// IDLE  | all domain resets asserted, waiting for start
// SEQ   | seq_cnt counting, domains released as seq_cnt hits their delay
// RUN   | all domains released, counting run cycles, watching for verdict
// PASS  | terminal, success latched, waiting for clear
// FAIL  | terminal, failure and reason latched, waiting for clear
module test_run_controller
  import test_run_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int DLY_W       = 16,
  parameter int CNT_W       = 64,
  parameter int STIM_W      = 12,
  parameter int PHASE_W     = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         clear,
  input  logic [NUM_DOMAINS*DLY_W-1:0] rel_delay,
  input  logic [CNT_W-1:0]             max_cycles,
  input  logic                         success_in,
  input  logic                         fail_in,
  input  logic [PHASE_W-1:0]           stim_step,
  output logic [NUM_DOMAINS-1:0]       domain_reset,
  output logic [CNT_W-1:0]             cycle_count,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [1:0]                   fail_reason,
  output logic [STIM_W-1:0]            stim_p,
  output logic [STIM_W-1:0]            stim_m
);

  state_t                 state_q, state_d;
  logic [DLY_W-1:0]       seq_cnt, seq_cnt_d;
  logic [NUM_DOMAINS-1:0] release_hit, rst_after, dreset_d;
  logic [CNT_W-1:0]       cnt_d;
  logic                   done_d, pass_d, fail_d;
  logic [1:0]             reason_d;

  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_hit
    assign release_hit[i] = (seq_cnt == rel_delay[i*DLY_W +: DLY_W]);
  end
  assign rst_after = domain_reset & ~release_hit;

  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt;
    dreset_d  = domain_reset;
    cnt_d     = cycle_count;
    done_d    = done;
    pass_d    = pass;
    fail_d    = fail;
    reason_d  = fail_reason;
    case (state_q)
      ST_IDLE: begin
        dreset_d = '1;
        if (start) begin
          state_d   = ST_SEQ;
          seq_cnt_d = '0;
        end
      end
      ST_SEQ: begin
        if (abort) begin
          state_d  = ST_FAIL;
          done_d   = 1'b1;
          fail_d   = 1'b1;
          reason_d = REASON_ABORT;
        end else begin
          seq_cnt_d = seq_cnt + 1'b1;
          dreset_d  = rst_after;
          if (rst_after == '0) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d  = ST_FAIL;
          done_d   = 1'b1;
          fail_d   = 1'b1;
          reason_d = REASON_ABORT;
        end else if (fail_in) begin
          state_d  = ST_FAIL;
          done_d   = 1'b1;
          fail_d   = 1'b1;
          reason_d = REASON_EXTERNAL;
        end else if ((max_cycles != '0) && (cycle_count == max_cycles)) begin
          state_d  = ST_FAIL;
          done_d   = 1'b1;
          fail_d   = 1'b1;
          reason_d = REASON_TIMEOUT;
        end else if (success_in) begin
          state_d = ST_PASS;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (cycle_count != '1) begin
          cnt_d = cycle_count + 1'b1;
        end
      end
      ST_PASS, ST_FAIL: begin
        if (clear) begin
          state_d  = ST_IDLE;
          dreset_d = '1;
          cnt_d    = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          fail_d   = 1'b0;
          reason_d = REASON_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      seq_cnt      <= '0;
      domain_reset <= '1;
      cycle_count  <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      fail_reason  <= REASON_NONE;
    end else begin
      state_q      <= state_d;
      seq_cnt      <= seq_cnt_d;
      domain_reset <= dreset_d;
      cycle_count  <= cnt_d;
      done         <= done_d;
      pass         <= pass_d;
      fail         <= fail_d;
      fail_reason  <= reason_d;
    end
  end

`ifdef TEST_RUN_STIM_EN
  stim_nco #(
    .STIM_W (STIM_W),
    .PHASE_W(PHASE_W)
  ) u_stim_nco (
    .clock  (clock),
    .reset_n(reset_n),
    .en     ((state_q == ST_SEQ) || (state_q == ST_RUN)),
    .step   (stim_step),
    .stim_p (stim_p),
    .stim_m (stim_m)
  );
`else
  logic stim_step_unused;
  assign stim_step_unused = ^stim_step;
  assign stim_p = '0;
  assign stim_m = '0;
`endif

endmodule
